// File: rtl/mem_handshake_ram.sv
// Byte-addressed big-endian RAM answering the MFA/MFC handshake after a
// programmable number of wait cycles; misaligned requests complete with ALIGN_ERR.
module mem_handshake_ram #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        RW,
  input  logic [1:0]  MOV_TYPE,
  input  logic        SE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        ALIGN_ERR
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [7:0] ram [0:DEPTH-1];

  state_t               state;
  logic [3:0]           cnt;
  logic                 rw_q;
  logic [1:0]           mov_q;
  logic                 se_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          data_q;

  logic                 req_rw;
  logic [1:0]           req_mov;
  logic                 req_se;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_data;
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic                 misalign;
  logic                 commit;
  logic                 wr_en;
  logic [31:0]          rd_data;
  logic                 unused_addr;

  // A zero-latency commit happens on the capture edge, so it must see the live inputs.
  assign req_rw   = (state == IDLE) ? RW : rw_q;
  assign req_mov  = (state == IDLE) ? MOV_TYPE : mov_q;
  assign req_se   = (state == IDLE) ? SE : se_q;
  assign req_addr = (state == IDLE) ? Address[ADDR_BITS-1:0] : addr_q;
  assign req_data = (state == IDLE) ? DataIn : data_q;

  assign a0 = req_addr;
  assign a1 = req_addr + ADDR_BITS'(1);
  assign a2 = req_addr + ADDR_BITS'(2);
  assign a3 = req_addr + ADDR_BITS'(3);

  assign misalign = ((req_mov == 2'b01) && req_addr[0]) ||
                    (req_mov[1] && (req_addr[1:0] != 2'b00));

  assign commit = MFA && (((state == IDLE) && (LAT == 4'd0)) ||
                          ((state == WAIT) && (cnt == 4'd1)));
  assign wr_en  = commit && Reset && !req_rw && !misalign;

  assign MFC         = (state == DONE);
  assign unused_addr = ^Address[31:ADDR_BITS];

  always_comb begin
    rd_data = 32'h0;
    case (req_mov)
      2'b00:   rd_data = {{24{req_se & ram[a0][7]}}, ram[a0]};
      2'b01:   rd_data = {{16{req_se & ram[a0][7]}}, ram[a0], ram[a1]};
      default: rd_data = {ram[a0], ram[a1], ram[a2], ram[a3]};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      case (req_mov)
        2'b00: ram[a0] <= req_data[7:0];
        2'b01: begin
          ram[a0] <= req_data[15:8];
          ram[a1] <= req_data[7:0];
        end
        default: begin
          ram[a0] <= req_data[31:24];
          ram[a1] <= req_data[23:16];
          ram[a2] <= req_data[15:8];
          ram[a3] <= req_data[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rw_q      <= 1'b0;
      mov_q     <= 2'b00;
      se_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'h0;
      DataOut   <= 32'h0;
      ALIGN_ERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MFA) begin
            rw_q   <= RW;
            mov_q  <= MOV_TYPE;
            se_q   <= SE;
            addr_q <= Address[ADDR_BITS-1:0];
            data_q <= DataIn;
            cnt    <= LAT;
            state  <= (LAT == 4'd0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!MFA) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state <= DONE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!MFA) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        ALIGN_ERR <= misalign;
        if (misalign) DataOut <= 32'h0;
        else if (req_rw) DataOut <= rd_data;
      end
    end
  end

endmodule
